// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: metadata record, FSM states, constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bru_pkg;

  // Address width the metadata record is built for; the top's XLEN must match it.
  localparam int unsigned BRU_XLEN = 32;

  // Fall-through distance for a not-taken / non-branch instruction.
  localparam int unsigned INSN_BYTES = 4;

  // Prediction carried alongside an instruction through IF/ID and ID/EX.
  typedef struct packed {
    logic                valid;
    logic [BRU_XLEN-1:0] pc;
    logic                pred_taken;
    logic [BRU_XLEN-1:0] pred_target;
  } pred_meta_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/bru_meta_stage.sv
// One prediction-metadata pipe register (IF/ID or ID/EX slot).
// Latency: 1 cycle from d to q when not stalled.
// Backpressure: stall holds contents; flush clears valid and overrides stall.
module bru_meta_stage
  import bru_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  input  pred_meta_t d,
  output pred_meta_t q
);

  pred_meta_t q_q;
  pred_meta_t q_d;

  // Load on advance, hold on stall; a squash always kills the slot.
  always_comb begin
    q_d = q_q;
    if (!stall) begin
      q_d = d;
    end
    if (flush) begin
      q_d.valid = 1'b0;
    end
  end

  // Metadata register; starts empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves predictions at EX: registered flush/redirect on mispredict, predictor update per resolved branch.
// Latency: 1 cycle from EX resolution to flush/redirect/update outputs; flush held FLUSH_CYCLES cycles.
// Backpressure: stall freezes the metadata pipe and suppresses resolution. Optional counters: BRU_PERF_CNT_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned XLEN         = BRU_XLEN,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             if_pred_taken,
  input  logic [XLEN-1:0]  if_pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_ctrl,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  output logic             flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic [XLEN-1:0]  upd_target,
  output logic             upd_taken,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] resolved_cnt
);

  pred_meta_t s1_in;
  pred_meta_t s1;
  pred_meta_t s2;

  bru_state_e      state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            upd_valid_q, upd_valid_d;
  logic [XLEN-1:0] upd_pc_q, upd_pc_d;
  logic [XLEN-1:0] upd_target_q, upd_target_d;
  logic            upd_taken_q, upd_taken_d;

  logic            pred_eff;
  logic            resolve;
  logic            mispredict;
  logic [XLEN-1:0] correct_pc;

  // Pack the fetched instruction's prediction into the IF/ID slot input.
  always_comb begin
    s1_in             = '0;
    s1_in.valid       = if_valid;
    s1_in.pc          = if_pc;
    s1_in.pred_taken  = if_pred_taken;
    s1_in.pred_target = if_pred_target;
  end

  bru_meta_stage u_stage_ifid (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush_q),
    .d     (s1_in),
    .q     (s1)
  );

  bru_meta_stage u_stage_idex (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush_q),
    .d     (s1),
    .q     (s2)
  );

  // Compare prediction vs outcome and sequence the flush window.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    upd_valid_d      = 1'b0;
    upd_pc_d         = upd_pc_q;
    upd_target_d     = upd_target_q;
    upd_taken_d      = upd_taken_q;

    // An empty ID/EX slot means no prediction was made for what sits in EX.
    pred_eff   = s2.valid & s2.pred_taken;
    resolve    = (state_q == RUN) & ex_valid & ~stall;
    mispredict = 1'b0;
    if (resolve) begin
      if (ex_is_ctrl) begin
        mispredict = (ex_taken != pred_eff) |
                     (ex_taken & pred_eff & (ex_target != s2.pred_target));
      end else begin
        mispredict = pred_eff;
      end
    end
    correct_pc = (ex_is_ctrl & ex_taken) ? ex_target : s2.pc + XLEN'(INSN_BYTES);

    if (resolve & (ex_is_ctrl | pred_eff)) begin
      upd_valid_d  = 1'b1;
      upd_pc_d     = s2.pc;
      upd_target_d = ex_target;
      upd_taken_d  = ex_taken & ex_is_ctrl;
    end

    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d          = FLUSH;
          cnt_d            = 2'(FLUSH_CYCLES - 1);
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = correct_pc;
        end
      end
      FLUSH: begin
        if (cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          cnt_d   = cnt_q - 2'd1;
          flush_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Control and output registers; reset aborts any flush in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= RUN;
      cnt_q            <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_target_q     <= '0;
      upd_taken_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_target_q     <= upd_target_d;
      upd_taken_q      <= upd_taken_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_target     = upd_target_q;
  assign upd_taken      = upd_taken_q;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  // Saturating event counters, stepped together with the pulse they count.
  always_comb begin
    mis_cnt_d = mis_cnt_q;
    res_cnt_d = res_cnt_q;
    if (redirect_valid_d && (mis_cnt_q != '1)) begin
      mis_cnt_d = mis_cnt_q + 1'b1;
    end
    if (upd_valid_d && (res_cnt_q != '1)) begin
      res_cnt_d = res_cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_cnt_q <= '0;
      res_cnt_q <= '0;
    end else begin
      mis_cnt_q <= mis_cnt_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  assign mispredict_cnt = mis_cnt_q;
  assign resolved_cnt   = res_cnt_q;
`else
  assign mispredict_cnt = '0;
  assign resolved_cnt   = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (FLUSH_CYCLES=3, CNT_W=2).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Counter expectations follow BRU_PERF_CNT_EN.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic        ex_is_ctrl;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [1:0]  mispredict_cnt;
  logic [1:0]  resolved_cnt;

  int n_cmp = 0;
  int n_err = 0;

`ifdef BRU_PERF_CNT_EN
  localparam logic [1:0] SAT = 2'd3;
`else
  localparam logic [1:0] SAT = 2'd0;
`endif

  branch_resolve_unit #(
    .XLEN         (32),
    .FLUSH_CYCLES (3),
    .CNT_W        (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .ex_valid       (ex_valid),
    .ex_is_ctrl     (ex_is_ctrl),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .mispredict_cnt (mispredict_cnt),
    .resolved_cnt   (resolved_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_if(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] tg);
    if_valid       = v;
    if_pc          = pc;
    if_pred_taken  = pt;
    if_pred_target = tg;
  endtask

  task automatic drv_ex(input logic v, input logic c, input logic t, input logic [31:0] tg);
    ex_valid   = v;
    ex_is_ctrl = c;
    ex_taken   = t;
    ex_target  = tg;
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    drv_if(0, 32'h0, 0, 32'h0);
    drv_ex(0, 0, 0, 32'h0);
    tick();
    tick();
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("rst_upd_pc", upd_pc, 32'd0);
    chk("rst_mis_cnt", {30'd0, mispredict_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Correct taken prediction.
    drv_if(1, 32'h100, 1, 32'h200);
    tick();
    drv_if(0, 32'h0, 0, 32'h0);
    tick();
    drv_ex(1, 1, 1, 32'h200);
    tick();
    drv_ex(0, 0, 0, 32'h0);
    chk("t1_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t1_upd_pc", upd_pc, 32'h100);
    chk("t1_upd_target", upd_target, 32'h200);
    chk("t1_upd_taken", {31'd0, upd_taken}, 32'd1);
    chk("t1_flush", {31'd0, flush}, 32'd0);
    chk("t1_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    tick();
    chk("t1_upd_pulse_end", {31'd0, upd_valid}, 32'd0);

    // Taken but not predicted; the two younger instructions get squashed.
    drv_if(1, 32'h40, 0, 32'h0);
    tick();
    drv_if(1, 32'h44, 1, 32'h999);
    tick();
    drv_if(1, 32'h48, 1, 32'h777);
    drv_ex(1, 1, 1, 32'h80);
    tick();
    chk("t2_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t2_redirect_pc", redirect_pc, 32'h80);
    chk("t2_flush", {31'd0, flush}, 32'd1);
    chk("t2_upd_pc", upd_pc, 32'h40);
    chk("t2_upd_taken", {31'd0, upd_taken}, 32'd1);
    // Stale predicted-taken metadata keeps flowing with valid low; EX holds a taken branch that must be ignored.
    drv_if(0, 32'h0, 1, 32'h555);
    drv_ex(1, 1, 1, 32'h123);
    tick();
    chk("t2_flush_c2", {31'd0, flush}, 32'd1);
    chk("t2_redirect_pulse_end", {31'd0, redirect_valid}, 32'd0);
    chk("t2_no_upd_in_flush_c2", {31'd0, upd_valid}, 32'd0);
    tick();
    chk("t2_flush_c3", {31'd0, flush}, 32'd1);
    chk("t2_no_upd_in_flush_c3", {31'd0, upd_valid}, 32'd0);
    tick();
    chk("t2_flush_done", {31'd0, flush}, 32'd0);
    chk("t2_no_upd_in_flush_c4", {31'd0, upd_valid}, 32'd0);
    // Squashed slots reach EX as non-branches: no prediction, so nothing to update.
    drv_ex(1, 0, 0, 32'h0);
    tick();
    chk("t2_squash1_upd", {31'd0, upd_valid}, 32'd0);
    chk("t2_squash1_redirect", {31'd0, redirect_valid}, 32'd0);
    drv_if(0, 32'h0, 0, 32'h0);
    tick();
    chk("t2_squash2_upd", {31'd0, upd_valid}, 32'd0);
    chk("t2_squash2_flush", {31'd0, flush}, 32'd0);
    drv_ex(0, 0, 0, 32'h0);
    tick();

    // Predicted taken, actually not taken, fall-through wraps to 0.
    drv_if(1, 32'hFFFF_FFFC, 1, 32'h1000);
    tick();
    drv_if(0, 32'h0, 0, 32'h0);
    tick();
    drv_ex(1, 1, 0, 32'hDEAD);
    tick();
    drv_ex(0, 0, 0, 32'h0);
    chk("t3_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t3_redirect_pc_wrap", redirect_pc, 32'h0);
    chk("t3_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t3_upd_taken", {31'd0, upd_taken}, 32'd0);
    chk("t3_upd_target", upd_target, 32'hDEAD);
    tick();
    tick();
    tick();
    chk("t3_flush_done", {31'd0, flush}, 32'd0);

    // Target mismatch; flush spans three cycles with EX ignored.
    drv_if(1, 32'h300, 1, 32'h400);
    tick();
    drv_if(0, 32'h0, 0, 32'h0);
    tick();
    drv_ex(1, 1, 1, 32'h500);
    tick();
    chk("t4_redirect_pc", redirect_pc, 32'h500);
    chk("t4_flush_c1", {31'd0, flush}, 32'd1);
    drv_ex(1, 1, 1, 32'h600);
    tick();
    chk("t4_flush_c2", {31'd0, flush}, 32'd1);
    chk("t4_ignored_c2", {31'd0, upd_valid | redirect_valid}, 32'd0);
    tick();
    chk("t4_flush_c3", {31'd0, flush}, 32'd1);
    chk("t4_ignored_c3", {31'd0, upd_valid | redirect_valid}, 32'd0);
    tick();
    chk("t4_flush_done", {31'd0, flush}, 32'd0);
    chk("t4_ignored_c4", {31'd0, upd_valid | redirect_valid}, 32'd0);
    drv_ex(0, 0, 0, 32'h0);
    tick();

    // Alias hit on a non-branch, held by a 2-cycle stall at EX.
    drv_if(1, 32'h10, 1, 32'h50);
    tick();
    drv_if(0, 32'h0, 0, 32'h0);
    tick();
    stall = 1'b1;
    drv_if(1, 32'h99, 1, 32'h88);
    drv_ex(1, 0, 0, 32'h0);
    tick();
    chk("t5_stall1_upd", {31'd0, upd_valid}, 32'd0);
    chk("t5_stall1_redirect", {31'd0, redirect_valid}, 32'd0);
    tick();
    chk("t5_stall2_upd", {31'd0, upd_valid}, 32'd0);
    chk("t5_stall2_redirect", {31'd0, redirect_valid}, 32'd0);
    stall = 1'b0;
    drv_if(0, 32'h0, 0, 32'h0);
    tick();
    chk("t5_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t5_redirect_pc", redirect_pc, 32'h14);
    chk("t5_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t5_upd_pc", upd_pc, 32'h10);
    chk("t5_upd_taken", {31'd0, upd_taken}, 32'd0);
    // A stall during the flush window must not stretch it.
    stall = 1'b1;
    drv_ex(0, 0, 0, 32'h0);
    tick();
    tick();
    chk("t5_flush_under_stall", {31'd0, flush}, 32'd1);
    tick();
    chk("t5_flush_done_under_stall", {31'd0, flush}, 32'd0);
    stall = 1'b0;
    tick();

    // Correct not-taken branch still trains the predictor.
    drv_if(1, 32'h500, 0, 32'h0);
    tick();
    drv_if(0, 32'h0, 0, 32'h0);
    tick();
    drv_ex(1, 1, 0, 32'h600);
    tick();
    drv_ex(0, 0, 0, 32'h0);
    chk("t6_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t6_upd_pc", upd_pc, 32'h500);
    chk("t6_upd_taken", {31'd0, upd_taken}, 32'd0);
    chk("t6_flush", {31'd0, flush}, 32'd0);
    chk("t6_redirect_valid", {31'd0, redirect_valid}, 32'd0);

    // Fifth mispredict, then reset in the middle of its flush.
    drv_if(1, 32'h700, 0, 32'h0);
    tick();
    drv_if(0, 32'h0, 0, 32'h0);
    tick();
    drv_ex(1, 1, 1, 32'h800);
    tick();
    drv_ex(0, 0, 0, 32'h0);
    chk("t7_redirect_pc", redirect_pc, 32'h800);
    chk("t7_mis_cnt_sat", {30'd0, mispredict_cnt}, {30'd0, SAT});
    chk("t7_res_cnt_sat", {30'd0, resolved_cnt}, {30'd0, SAT});
    tick();
    chk("t7_flush_before_rst", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t7_rst_flush", {31'd0, flush}, 32'd0);
    chk("t7_rst_mis_cnt", {30'd0, mispredict_cnt}, 32'd0);
    chk("t7_rst_res_cnt", {30'd0, resolved_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Back in RUN after reset: a correct prediction resolves normally.
    drv_if(1, 32'h900, 1, 32'hA00);
    tick();
    drv_if(0, 32'h0, 0, 32'h0);
    tick();
    drv_ex(1, 1, 1, 32'hA00);
    tick();
    drv_ex(0, 0, 0, 32'h0);
    chk("t8_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t8_upd_pc", upd_pc, 32'h900);
    chk("t8_flush", {31'd0, flush}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Back end of the fetch-prediction loop: carries each fetched instruction's prediction (taken bit, target) down the IF->ID->EX pipe alongside the instruction.
- At EX, compares the prediction with the actual branch outcome.
- On mismatch: issues a registered pipeline flush plus a redirect PC to fetch.
- Always emits a registered training/update request back to the predictor for every resolved control-flow instruction.

Parameters:
- XLEN, 32, address/data width.
- FLUSH_CYCLES, 1, cycles flush stays asserted after a mispredict (1..4).
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold IF/ID and ID/EX metadata stages (no shift).
- if_valid  in  1  instruction accepted into IF/ID this cycle.
- if_pc  in  XLEN  PC of that instruction.
- if_pred_taken  in  1  predictor said taken.
- if_pred_target  in  XLEN  predicted target (don't-care when not taken).
- ex_valid  in  1  EX holds a real instruction.
- ex_is_ctrl  in  1  EX instruction is branch/jump.
- ex_taken  in  1  actual outcome.
- ex_target  in  XLEN  actual computed target.
- flush  out  1  squash IF/ID and ID/EX.
- redirect_valid  out  1  fetch must load redirect_pc.
- redirect_pc  out  XLEN  corrected fetch address.
- upd_valid  out  1  predictor update strobe.
- upd_pc  out  XLEN  PC being trained.
- upd_target  out  XLEN  actual target.
- upd_taken  out  1  actual outcome.
- mispredict_cnt  out  CNT_W  mispredictions (only with BRU_PERF_CNT_EN).
- resolved_cnt  out  CNT_W  resolved control-flow instructions (only with BRU_PERF_CNT_EN).

Behaviour:
- Reset: all outputs 0, metadata stages invalid, FSM = RUN. Reset mid-flush aborts the flush immediately.
- Metadata pipe:
  - Stage1 (IF/ID) and stage2 (ID/EX) each hold {valid, pc, pred_taken, pred_target}.
  - When stall=0: stage1 <= if_* and stage2 <= stage1.
  - When stall=1: both hold.
  - When flush=1: both valid bits cleared that cycle, overriding stall.
  - EX resolution uses stage2 contents.
- Resolution (RUN, ex_valid=1, stage2.valid=1, stall=0) -- mispredict when any of:
  - (a) ex_is_ctrl, ex_taken=1, pred_taken=0
  - (b) ex_is_ctrl, ex_taken=0, pred_taken=1
  - (c) ex_is_ctrl, both taken, ex_target != pred_target
  - (d) ex_is_ctrl=0, pred_taken=1 (alias hit)
- Correct PC: ex_target if ex_is_ctrl && ex_taken, else stage2.pc+4 (mod 2^XLEN, wraps).
- Latency: all outputs registered, 1 cycle after resolution.
  - On mispredict: redirect_valid=1 for exactly one cycle with redirect_pc; flush=1 for FLUSH_CYCLES cycles.
  - On a correct prediction: no flush, no redirect.
- Update:
  - upd_valid=1 for one cycle for every resolved instruction with ex_is_ctrl=1, and also for case (d).
  - upd_pc = stage2.pc, upd_target = ex_target, upd_taken = ex_taken & ex_is_ctrl.
  - Updates are issued for correct predictions as well.
- FSM:
  - RUN -> FLUSH on mispredict, loading a down-counter with FLUSH_CYCLES-1.
  - FLUSH: flush=1; counter decrements; at 0 -> RUN.
  - In FLUSH no resolution occurs: ex_valid is ignored and no upd_valid is issued.
- Stall at EX: no resolution, outputs pulse-free (upd_valid/redirect_valid=0); flush still completes.
- ex_valid=1 with stage2.valid=0 (bubble mismatch): treated as no prediction (pred_taken=0).

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - resolved_cnt increments per upd_valid pulse; mispredict_cnt increments per redirect_valid pulse.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Shared package bru_pkg:
  - pred_meta_t struct {valid, pc, pred_taken, pred_target}.
  - State enum {RUN, FLUSH}.
  - Constant INSN_BYTES=4.
- One sub-module: bru_meta_stage (single stall/flush-aware metadata register), instantiated twice.

Test Plan:
- Correct taken: pc 0x100 predicted taken to 0x200, actual taken 0x200 -> upd_valid=1, upd_pc=0x100, upd_taken=1, flush=0, redirect_valid=0.
- Taken, not predicted: pc 0x40 pred_taken=0, actual taken to 0x80 -> next cycle flush=1, redirect_pc=0x80; the following two instructions arrive with valid=0 and produce no updates.
- Predicted taken, not taken: pc 0xFFFFFFFC pred_taken=1 -> redirect_pc=0x00000000 (wrap), upd_taken=0.
- Target mismatch: pc 0x300 pred 0x400, actual 0x500 -> redirect_pc=0x500. With FLUSH_CYCLES=3: flush high 3 cycles, ex_valid ignored throughout.
- Alias plus stall: non-branch at 0x10 with pred_taken=1, stall held 2 cycles before EX -> no output during stall; then redirect_pc=0x14, upd_taken=0.
- Reset mid-flush plus counters: assert rst during FLUSH -> flush=0 immediately, counters 0. With BRU_PERF_CNT_EN and CNT_W=2, 5 mispredicts -> mispredict_cnt=3.
